// File: rtl/iiitb_icg_pkg.sv
// Shared types and helpers for the clock-gated register bank.
package iiitb_icg_pkg;

  // Per-channel gating state: RUN keeps the gate open, GATED lets data wake it.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_GATED = 1'b1
  } ch_state_e;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/iiitb_icg_cell.sv
// Latch-based glitch-free clock gate: the enable is captured while clk is low
// and held while clk is high, so gclk can only pulse for a whole clk high phase.
module iiitb_icg_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic gclk
);

  logic r_lat;

  // Enable latch, transparent during clk low, forced closed during reset.
  always_latch begin
    if (!rst_n) begin
      r_lat <= 1'b0;
    end else if (!clk) begin
      r_lat <= req;
    end
  end

  assign gclk = clk & r_lat;

endmodule

// File: rtl/iiitb_icg_bank.sv
// Bank of independently clock-gated enabled registers. Each channel shuts its
// own clock after IDLE_CYCLES edges without a data change (or when disabled)
// and reopens it in the same cycle that new data arrives.
//
// Handshake note: there is no valid/ready here. en/d are sampled at every clk
// rising edge; q follows d one edge later whenever en (or test_en) is high.
module iiitb_icg_bank
  import iiitb_icg_pkg::*;
#(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned IDLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  test_en,
  input  logic [N_CH-1:0]       en,
  input  logic [N_CH*WIDTH-1:0] d,
  output logic [N_CH*WIDTH-1:0] q,
  output logic [N_CH-1:0]       gated_o
);

  localparam int unsigned      CW       = cnt_width(IDLE_CYCLES);
  localparam logic [CW-1:0]    CNT_LAST = CW'(IDLE_CYCLES - 1);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [WIDTH-1:0] w_d;
    logic [WIDTH-1:0] r_q;
    logic             w_act;
    logic             w_req;
    logic             w_gclk;
    ch_state_e        r_state;
    ch_state_e        w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;

    assign w_d   = d[gi*WIDTH +: WIDTH];
    assign w_act = (w_d != r_q);
    // In GATED only a real data change may open the gate, which is what makes
    // the wake-up free of a bubble: the very edge carrying new data is passed.
    assign w_req = test_en | (en[gi] & (w_act | (r_state == ST_RUN)));

    iiitb_icg_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (w_req),
      .gclk  (w_gclk)
    );

    // Channel data register on the gated clock; a pulse always means "load".
    always_ff @(posedge w_gclk or negedge rst_n) begin
      if (!rst_n) begin
        r_q <= '0;
      end else begin
        r_q <= w_d;
      end
    end

    // Idle-detector state and counter on the free-running clock.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= ST_RUN;
        r_cnt   <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
      end
    end

    // Next-state: activity beats an expiring idle count on the same edge.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
        ST_RUN: begin
          if (!en[gi]) begin
            w_state_nxt = ST_GATED;
            w_cnt_nxt   = '0;
          end else if (w_act) begin
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = ST_GATED;
          end else begin
            w_cnt_nxt   = r_cnt + CW'(1);
          end
        end
        ST_GATED: begin
          if (en[gi] && w_act) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    assign q[gi*WIDTH +: WIDTH] = r_q;
    assign gated_o[gi]          = (r_state == ST_GATED) & ~test_en;
  end

endmodule

// File: tb/tb_iiitb_icg_bank.sv
// Self-checking bench for iiitb_icg_bank (2 channels x 8 bits, 4 idle cycles).
`timescale 1ns/1ps
module tb_iiitb_icg_bank;

  localparam int NCH  = 2;
  localparam int W    = 8;
  localparam int IDLE = 4;
  localparam realtime HALF = 5.0;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst_n;
  logic            test_en;
  logic [NCH-1:0]  en;
  logic [NCH*W-1:0] d;
  wire  [NCH*W-1:0] q;
  wire  [NCH-1:0]   gated_o;
  logic [NCH-1:0]   tb_gclk;

  always #(HALF) clk = ~clk;

  iiitb_icg_bank #(.N_CH(NCH), .WIDTH(W), .IDLE_CYCLES(IDLE)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .test_en (test_en),
    .en      (en),
    .d       (d),
    .q       (q),
    .gated_o (gated_o)
  );

  assign tb_gclk[0] = dut.g_ch[0].w_gclk;
  assign tb_gclk[1] = dut.g_ch[1].w_gclk;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Ungated view: q loads d whenever the channel is enabled or under test.
  // Gating view: a channel goes off once it has seen IDLE consecutive enabled
  // edges with no data change, or any disabled edge; it comes back on an
  // enabled edge that carries new data.
  logic [W-1:0] q_m [NCH];
  bit           gated_m [NCH];
  int           idle_m [NCH];
  logic [NCH-1:0] pulse_m;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      q_m[i] = '0; gated_m[i] = 1'b0; idle_m[i] = 0;
    end
    pulse_m = '0;
  endtask

  task automatic model_edge();
    for (int i = 0; i < NCH; i++) begin
      logic [W-1:0] di;
      bit change;
      di = d[i*W +: W];
      change = (di != q_m[i]);
      pulse_m[i] = test_en | (en[i] & (change | !gated_m[i]));
      if (!gated_m[i]) begin
        if (!en[i]) begin
          gated_m[i] = 1'b1; idle_m[i] = 0;
        end else if (change) begin
          idle_m[i] = 0;
        end else begin
          idle_m[i]++;
          if (idle_m[i] >= IDLE) begin
            gated_m[i] = 1'b1; idle_m[i] = 0;
          end
        end
      end else if (en[i] && change) begin
        gated_m[i] = 1'b0; idle_m[i] = 0;
      end
      if (test_en || en[i]) q_m[i] = di;
    end
  endtask

  function automatic logic [NCH*W-1:0] exp_q();
    return {q_m[1], q_m[0]};
  endfunction

  function automatic logic [NCH-1:0] exp_gated();
    return {gated_m[1] & ~test_en, gated_m[0] & ~test_en};
  endfunction

  // ---------------- driver tasks ----------------
  // One clk cycle: inputs already driven at the previous falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("q", 64'(q), 64'(exp_q()));
    check("gated_o", 64'(gated_o), 64'(exp_gated()));
    check("gclk_pulse", 64'(tb_gclk), 64'(pulse_m));
    @(negedge clk);
  endtask

  // ---------------- gclk shape monitors ----------------
  realtime t_rise [NCH];

  always @(posedge tb_gclk[0]) begin
    t_rise[0] = $realtime;
    check("gclk0_rise_clk_high", 64'(clk), 64'd1);
  end
  always @(posedge tb_gclk[1]) begin
    t_rise[1] = $realtime;
    check("gclk1_rise_clk_high", 64'(clk), 64'd1);
  end
  always @(negedge tb_gclk[0]) if (rst_n)
    check("gclk0_width_ps", 64'(longint'(($realtime - t_rise[0]) * 1000.0)), 64'd5000);
  always @(negedge tb_gclk[1]) if (rst_n)
    check("gclk1_width_ps", 64'(longint'(($realtime - t_rise[1]) * 1000.0)), 64'd5000);

  // ---------------- watchdog ----------------
  initial begin
    #(2_000_000);
    $display("FAIL watchdog: got timeout expected finish");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; test_en = 1'b0; en = '0; d = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_q", 64'(q), 64'd0);
    check("reset_gated", 64'(gated_o), 64'd0);

    // Gating entry on ch0 after IDLE idle edges, then zero-latency wake-up.
    en = 2'b11; d = {8'h00, 8'h11};
    step();
    check("load_q0", 64'(q[7:0]), 64'h11);
    for (int k = 1; k <= IDLE; k++) begin
      step();
      check("idle_gated0", 64'(gated_o[0]), 64'(k == IDLE));
    end
    step();
    check("gclk0_stopped", 64'(tb_gclk[0]), 64'd0);
    check("gated0_held", 64'(gated_o[0]), 64'd1);
    d[7:0] = 8'h22;
    step();
    check("wake_q0", 64'(q[7:0]), 64'h22);
    check("wake_gated0", 64'(gated_o[0]), 64'd0);

    // New data on the edge where the idle count would expire.
    for (int k = 0; k < IDLE - 1; k++) step();
    d[7:0] = 8'h33;
    step();
    check("collide_q0", 64'(q[7:0]), 64'h33);
    check("collide_gated0", 64'(gated_o[0]), 64'd0);
    for (int k = 1; k <= IDLE; k++) begin
      step();
      check("recount_gated0", 64'(gated_o[0]), 64'(k == IDLE));
    end

    // ch1 disabled while its data toggles; ch0 keeps working.
    en = 2'b01; d[7:0] = 8'h44;
    for (int k = 0; k < 6; k++) begin
      d[15:8] = (k % 2 == 0) ? 8'hFF : 8'h00;
      step();
      check("frozen_q1", 64'(q[15:8]), 64'h00);
      check("disabled_gated1", 64'(gated_o[1]), 64'd1);
      check("ch0_unaffected", 64'(q[7:0]), 64'h44);
    end

    // Test override opens every gate regardless of en.
    en = 2'b00; test_en = 1'b1; d = 16'h5A5A;
    step();
    check("test_q", 64'(q), 64'h5A5A);
    check("test_gated", 64'(gated_o), 64'd0);
    test_en = 1'b0;
    step();
    check("post_test_gated", 64'(gated_o), 64'b11);
    check("post_test_q", 64'(q), 64'h5A5A);

    // Mid-run reset: q clears at once, no gclk pulses while held.
    en = 2'b11; d = {8'h3C, 8'hA5};
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_q", 64'(q), 64'd0);
    check("midrst_gated", 64'(gated_o), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("midrst_no_gclk", 64'(tb_gclk), 64'd0);
      check("midrst_q_hold", 64'(q), 64'd0);
    end
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 3) == 0) d[i*W +: W] = W'($urandom_range(0, 255));
        en[i] = ($urandom_range(0, 7) != 0);
      end
      test_en = ($urandom_range(0, 39) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/iiitb_icg_bank.md
# iiitb_icg_bank

Parametrised bank of `N_CH` clock-gated register channels, each `WIDTH` bits wide. Every channel has its own latch-based glitch-free clock gate and an idle detector. The detector shuts the channel's clock after `IDLE_CYCLES` consecutive cycles with no data change, and reopens it with zero added latency when new data arrives. Functionally each channel is an enabled register (`q` loads `d` when `en` is high). Gating only saves power; it never changes captured values. The bank sits between the datapath and the free-running `clk` as the multi-channel successor to the single-enable two-flop ICG.

## Interface
- `N_CH`, 2, number of independent channels (1..32)
- `WIDTH`, 1, data bits per channel (1..64)
- `IDLE_CYCLES`, 4, consecutive idle cycles before gating (2..255)
- `clk` input 1, free-running clock
- `rst_n` input 1, asynchronous active-low reset
- `test_en` input 1, scan/test override: forces every gated clock on
- `en` input `N_CH`, per-channel functional enable
- `d` input `N_CH*WIDTH`, channel data; channel i occupies bits [i*WIDTH +: WIDTH]
- `q` output `N_CH*WIDTH`, registered channel data, clocked by that channel's gated clock
- `gated_o` output `N_CH`, 1 = channel i's clock is currently off

## Operation
- Per channel: `act_i = (d_i != q_i)`. The FSM runs on free `clk`. States are RUN and GATED. Each channel has an idle counter `cnt_i` of width clog2(`IDLE_CYCLES`).
- Gate request: `req_i = test_en | (en_i & (act_i | state_i==RUN))`.
- Gated clock: `gclk_i = clk & lat_i`, where `lat_i` is a latch that is transparent while `clk` is low. `q_i` captures `d_i` on every `gclk_i` rising edge.
- RUN transitions:
  - `en_i=0`: go to GATED and clear `cnt_i`.
  - `en_i=1` and `act_i=1`: clear `cnt_i` and stay in RUN.
  - `en_i=1` and `act_i=0`: if `cnt_i==IDLE_CYCLES-1`, go to GATED; otherwise increment `cnt_i`.
- GATED transitions:
  - `en_i=1` and `act_i=1`: go to RUN and clear `cnt_i`.
  - Otherwise: hold.
- `gated_o[i]` is 1 when `state_i==GATED` and `test_en==0`.
- `test_en=1`:
  - All gates are open and `q` loads `d` every cycle, regardless of `en`.
  - The FSMs and counters keep updating as above. `gated_o` reads 0.
- Channels are fully independent. No arbitration or shared state exists.

## Timing
- Reset (async assert, sync deassert handled externally): `q`=0, every state=RUN, every `cnt`=0, `gated_o`=0. Gated-clock flops take `rst_n` directly.
- Data latency: `q_i` equals the `d_i` value sampled at the first `clk` rising edge where `en_i=1`, one cycle, in both RUN and GATED. There is no wake-up bubble.
- Gating entry: with `IDLE_CYCLES=N` and `en_i=1`, `d_i==q_i` held, `gated_o[i]` rises after the N-th idle edge. The first suppressed `gclk_i` edge is the (N+1)-th.
- `en_i` deassertion: `gated_o[i]` rises after the same edge and `q_i` holds. `en_i` and `d_i` must meet setup to the `clk` rising edge. `lat_i` closes on `clk` high, so `gclk_i` is glitch-free.
- Simultaneous idle-timeout and new data on the same edge: act wins. The channel stays in RUN, `cnt` clears, and `q` loads.
- Mid-operation reset: all channels return to RUN with `q`=0 immediately. `lat_i` is forced closed during reset, so no `gclk_i` pulse occurs.

## Structure
- Package `iiitb_icg_pkg`: state enum (RUN, GATED) and a clog2 counter-width function.
- Sub-module `iiitb_icg_cell`: one latch plus AND gate, with `clk`, `rst_n`, `req`, `gclk`. It is instantiated once per channel. Synthesis maps it to the library ICG.
- The top generates `N_CH` channel slices, each containing an FSM, counter, and `WIDTH`-bit register.

## Test plan
- Reset mid-run with `N_CH=2`, `WIDTH=8`, `d`=0xA5/0x3C, `en`=11 → `q`=0, `gated_o`=00 while `rst_n`=0, and no `gclk` pulses.
- `IDLE_CYCLES=4`, ch0 `d` constant 0x11 after load, `en0`=1 → `gated_o[0]` rises after the 4th idle edge and `gclk0` stops. Then `d0`=0x22 → `q0`=0x22 on the next edge and `gated_o[0]` falls.
- `d0` changes on the same edge the counter would expire (cnt=3) → `q0` updates, no gating occurs, cnt=0.
- `en1`=0 while `d1` toggles 0x00/0xFF every cycle → `q1` frozen, `gated_o[1]`=1, ch0 unaffected.
- `test_en`=1 with `en`=00, `d`=0x5A5A → `q` loads 0x5A5A next edge and `gated_o`=00. Release `test_en` → prior gating state resumes.
- Random `d`/`en` for 3000 cycles against an ungated reference model (`q` loads `d` when `en` is high) → `q` matches every cycle, and `gclk` high-pulse width always equals `clk` high phase.
